uart_frame_parser: RTL and testbench

//  Consumes the byte stream from the UART receiver (8-bit data + 1-cycle valid pulse, no backpressure)
//  and extracts framed commands: SOF, CMD, LEN, LEN payload bytes, CHK. A good frame is held in a

---
 rtl/uart_frame_parser_pkg.sv | 24 ++
 rtl/uart_frame_parser_if.sv | 35 +++
 rtl/uart_frame_buf.sv | 28 ++
 rtl/uart_frame_parser.sv | 135 +++++++++++++
 tb/tb_uart_frame_parser.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: FSM states, the default SOF marker and parameter helpers.
// Combinational helpers only; no flow control.
package uart_frame_parser_pkg;

  typedef enum logic [2:0] {
    S_SOF,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

  function automatic int timeout_cycles(input int clk_freq);
    return clk_freq / 1000;
  endfunction

  function automatic int addr_width(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte stream in, held-frame handshake and payload read port out of the frame parser.
// master = byte source / command layer, slave = parser.
interface uart_frame_parser_if
  import uart_frame_parser_pkg::*;
#(
  parameter int MAX_LEN = 16
);
  localparam int AW = addr_width(MAX_LEN);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          frame_ready;
  logic [7:0]    frame_cmd;
  logic [7:0]    frame_len;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_chk;
  logic          err_len;
  logic          err_timeout;
  logic          err_overrun;

  modport master (
    output rx_data, rx_valid, frame_ack, rd_addr,
    input  frame_ready, frame_cmd, frame_len, rd_data,
    input  err_chk, err_len, err_timeout, err_overrun
  );

  modport slave (
    input  rx_data, rx_valid, frame_ack, rd_addr,
    output frame_ready, frame_cmd, frame_len, rd_data,
    output err_chk, err_len, err_timeout, err_overrun
  );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, sync write, registered read (1-cycle latency).
// No backpressure; a read and a write to the same address return the old byte.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is cleared, so rd_data reads 0 out of reset; storage is left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/CMD/LEN/payload/CHK frames from a valid-pulsed byte stream and holds a good frame until acked.
// Outputs registered (frame_ready one cycle after CHK); input cannot be stalled, bytes arriving while held are dropped.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int         CLK_FREQ    = 100_000_000,
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = timeout_cycles(CLK_FREQ)
) (
  input logic               clk,
  input logic               rst_n,
  uart_frame_parser_if.slave bus
);

  localparam int              AW        = addr_width(MAX_LEN);
  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0]   TMR_LAST  = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [7:0]    cmd_q;
  logic [7:0]    len_q;
  logic [7:0]    chk_q;
  logic [7:0]    idx_q;
  logic [TW-1:0] tmr_q;
  logic          ready_q;
  logic          err_chk_q;
  logic          err_len_q;
  logic          err_to_q;
  logic          err_ovr_q;
  logic          wr_en;

  assign wr_en = bus.rx_valid && (state == S_PAYLOAD);

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (idx_q[AW-1:0]),
    .wr_data (bus.rx_data),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  assign bus.frame_ready = ready_q;
  assign bus.frame_cmd   = cmd_q;
  assign bus.frame_len   = len_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_overrun = err_ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_SOF;
      cmd_q     <= '0;
      len_q     <= '0;
      chk_q     <= '0;
      idx_q     <= '0;
      tmr_q     <= '0;
      ready_q   <= 1'b0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_ovr_q <= 1'b0;
      case (state)
        S_SOF: begin
          tmr_q <= '0;
          if (bus.rx_valid && bus.rx_data == SOF_BYTE) state <= S_CMD;
        end
        S_HOLD: begin
          if (bus.rx_valid) err_ovr_q <= 1'b1;
          if (bus.frame_ack) begin
            ready_q <= 1'b0;
            state   <= S_SOF;
          end
        end
        default: begin
          // A byte in the same cycle as the timeout deadline takes priority.
          if (bus.rx_valid) begin
            tmr_q <= '0;
            case (state)
              S_CMD: begin
                cmd_q <= bus.rx_data;
                chk_q <= bus.rx_data;
                state <= S_LEN;
              end
              S_LEN: begin
                if (bus.rx_data > MAX_LEN_B) begin
                  err_len_q <= 1'b1;
                  state     <= S_SOF;
                end else begin
                  len_q <= bus.rx_data;
                  chk_q <= chk_q ^ bus.rx_data;
                  idx_q <= '0;
                  state <= (bus.rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
                end
              end
              S_PAYLOAD: begin
                chk_q <= chk_q ^ bus.rx_data;
                if (idx_q == len_q - 8'd1) state <= S_CHK;
                else                       idx_q <= idx_q + 8'd1;
              end
              S_CHK: begin
                if (bus.rx_data == chk_q) begin
                  ready_q <= 1'b1;
                  state   <= S_HOLD;
                end else begin
                  err_chk_q <= 1'b1;
                  state     <= S_SOF;
                end
              end
              default: state <= S_SOF;
            endcase
          end else if (tmr_q == TMR_LAST) begin
            err_to_q <= 1'b1;
            state    <= S_SOF;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a byte-queue reference model checked every cycle.
module tb_uart_frame_parser;
  localparam int MAX_LEN  = 16;
  localparam int CLK_FREQ = 100_000;
  localparam int T_OUT    = CLK_FREQ / 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_frame_parser #(
    .CLK_FREQ    (CLK_FREQ),
    .SOF_BYTE    (8'hAA),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (T_OUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_last = 0;
  int t_err  = 0;
  int c_chk = 0, c_len = 0, c_to = 0, c_ov = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the current frame kept in a queue, checksum recomputed at the end.
  bit         m_in, m_hold, m_rd_vld;
  bit         m_echk, m_elen, m_eto, m_eov;
  int         gap;
  logic [7:0] q[$];
  logic [7:0] m_cmd, m_len, m_rd;
  logic [7:0] mbuf [256];

  task automatic model_step();
    int n;
    logic [7:0] x;
    if (!rst_n) begin
      m_in = 0; m_hold = 0; m_rd_vld = 0; gap = 0; q.delete();
      m_cmd = 8'h00; m_len = 8'h00;
      m_echk = 0; m_elen = 0; m_eto = 0; m_eov = 0;
      return;
    end
    m_rd     = mbuf[bus.rd_addr];
    m_rd_vld = m_hold && (32'(bus.rd_addr) < 32'(m_len));
    m_echk = 0; m_elen = 0; m_eto = 0; m_eov = 0;
    if (m_hold) begin
      if (bus.rx_valid) m_eov = 1;
      if (bus.frame_ack) m_hold = 0;
    end else if (!m_in) begin
      if (bus.rx_valid && bus.rx_data == 8'hAA) begin
        m_in = 1; gap = 0; q.delete();
      end
    end else if (bus.rx_valid) begin
      gap = 0;
      q.push_back(bus.rx_data);
      n = q.size();
      if (n == 2 && int'(bus.rx_data) > MAX_LEN) begin
        m_elen = 1; m_in = 0;
      end else if (n >= 3 && n == int'(q[1]) + 3) begin
        x = 8'h00;
        for (int i = 0; i < n - 1; i++) x = x ^ q[i];
        if (bus.rx_data == x) begin
          m_hold = 1; m_cmd = q[0]; m_len = q[1];
        end else begin
          m_echk = 1;
        end
        m_in = 0;
      end else if (n >= 3) begin
        mbuf[n-3] = bus.rx_data;
      end
    end else begin
      gap++;
      if (gap == T_OUT) begin
        m_eto = 1; m_in = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (bus.err_chk)     c_chk++;
    if (bus.err_len)     c_len++;
    if (bus.err_overrun) c_ov++;
    if (bus.err_timeout) begin c_to++; t_err = cyc; end
    if (cmp_en) begin
      check("frame_ready", 32'(bus.frame_ready), 32'(m_hold));
      check("err_chk",     32'(bus.err_chk),     32'(m_echk));
      check("err_len",     32'(bus.err_len),     32'(m_elen));
      check("err_timeout", 32'(bus.err_timeout), 32'(m_eto));
      check("err_overrun", 32'(bus.err_overrun), 32'(m_eov));
      if (m_hold) begin
        check("frame_cmd", 32'(bus.frame_cmd), 32'(m_cmd));
        check("frame_len", 32'(bus.frame_len), 32'(m_len));
      end
      if (m_rd_vld) check("rd_data", 32'(bus.rd_data), 32'(m_rd));
    end
  end

  // Stimulus tasks are entered and left 2 time units after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 t_last = cyc;
    #1 bus.rx_valid = 1'b0;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] seq[$];

  task automatic send_seq();
    foreach (seq[i]) send(seq[i]);
  endtask

  task automatic expect_frame(input string name, input logic [7:0] cmd, input logic [7:0] len);
    @(negedge clk);
    check({name, ".ready"}, 32'(bus.frame_ready), 32'd1);
    check({name, ".cmd"},   32'(bus.frame_cmd),   32'(cmd));
    check({name, ".len"},   32'(bus.frame_len),   32'(len));
    @(posedge clk);
    #2;
  endtask

  task automatic read_chk(input string name, input int addr, input logic [7:0] exp);
    bus.rd_addr = 4'(addr);
    @(posedge clk);
    @(negedge clk);
    check(name, 32'(bus.rd_data), 32'(exp));
    @(posedge clk);
    #2;
  endtask

  task automatic ack();
    bus.frame_ack = 1'b1;
    @(posedge clk);
    #2 bus.frame_ack = 1'b0;
    @(negedge clk);
    check("ack.ready_low", 32'(bus.frame_ready), 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] x;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.frame_ack = 1'b0; bus.rd_addr = '0;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("reset.ready", 32'(bus.frame_ready), 32'd0);
    check("reset.cmd",   32'(bus.frame_cmd),   32'd0);
    check("reset.len",   32'(bus.frame_len),   32'd0);
    check("reset.rd",    32'(bus.rd_data),     32'd0);
    check("reset.errs",  {28'd0, bus.err_chk, bus.err_len, bus.err_timeout, bus.err_overrun}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(2);

    // Basic frame, readback, overrun while held, release.
    seq = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    send_seq();
    expect_frame("good1", 8'h01, 8'h02);
    read_chk("good1.rd0", 0, 8'h10);
    read_chk("good1.rd1", 1, 8'h20);
    send(8'h77);
    check("overrun.count", 32'(c_ov), 32'd1);
    read_chk("overrun.rd0", 0, 8'h10);
    ack();

    // Bad checksum, then a good frame; ack while idle is ignored.
    seq = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
    send_seq();
    check("badchk.count", 32'(c_chk), 32'd1);
    bus.frame_ack = 1'b1;
    idle(2);
    bus.frame_ack = 1'b0;
    seq = '{8'hAA, 8'h03, 8'h01, 8'h5A, 8'h58};
    send_seq();
    expect_frame("good2", 8'h03, 8'h01);
    read_chk("good2.rd0", 0, 8'h5A);
    ack();

    // Leading garbage and zero-length payload.
    seq = '{8'h55, 8'hAA, 8'h05, 8'h00, 8'h05};
    send_seq();
    expect_frame("len0", 8'h05, 8'h00);
    check("len0.no_errs", 32'(c_chk + c_len + c_to), 32'd1);
    ack();

    // LEN above MAX_LEN; trailing bytes ignored until the next SOF.
    seq = '{8'hAA, 8'h01, 8'h11, 8'h44, 8'h55, 8'h01};
    send_seq();
    check("lenerr.count", 32'(c_len), 32'd1);
    check("lenerr.ready", 32'(bus.frame_ready), 32'd0);

    // Maximum length payload.
    seq = '{8'hAA, 8'h09, 8'h10};
    x = 8'h09 ^ 8'h10;
    for (int i = 0; i < MAX_LEN; i++) begin
      seq.push_back(8'(i * 3));
      x = x ^ 8'(i * 3);
    end
    seq.push_back(x);
    send_seq();
    expect_frame("maxlen", 8'h09, 8'h10);
    read_chk("maxlen.rd15", 15, 8'h2D);
    read_chk("maxlen.rd0", 0, 8'h00);
    ack();

    // Inter-byte timeout.
    send(8'hAA);
    send(8'h01);
    idle(T_OUT + 10);
    check("timeout.count", 32'(c_to), 32'd1);
    check("timeout.delay", 32'(t_err - t_last), 32'(T_OUT));
    seq = '{8'hAA, 8'h04, 8'h00, 8'h04};
    send_seq();
    expect_frame("after_to", 8'h04, 8'h00);
    ack();

    // Reset in the middle of a payload.
    seq = '{8'hAA, 8'h01, 8'h04, 8'h11, 8'h22};
    send_seq();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.ready", 32'(bus.frame_ready), 32'd0);
    check("midrst.cmd",   32'(bus.frame_cmd),   32'd0);
    check("midrst.rd",    32'(bus.rd_data),     32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(1);
    seq = '{8'hAA, 8'h02, 8'h01, 8'h7E, 8'h7D};
    send_seq();
    expect_frame("after_rst", 8'h02, 8'h01);
    read_chk("after_rst.rd0", 0, 8'h7E);
    ack();

    idle(3);
    check("total.chk", 32'(c_chk), 32'd1);
    check("total.len", 32'(c_len), 32'd1);
    check("total.to",  32'(c_to),  32'd1);
    check("total.ov",  32'(c_ov),  32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
